// File: rtl/cpu_pkg.sv
// Shared CPU package: architectural widths, register-file constants and the
// writeback request record carried from the execution units to the register
// file write port.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot register select used to build pending-destination masks.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Count-based synchronous FIFO of writeback requests.
// Ports:
//   clk, rst           clock, synchronous active-high reset (pointers/count only)
//   push, din          write din at tail (ignored when full)
//   pop                drop head (ignored when empty)
//   full, empty        status from the registered count
//   head               request at the head
//   ent_valid/ent_addr per-slot occupancy and destination, for hazard masks
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  wb_req_t                        din,
  output logic                           full,
  output logic                           empty,
  output wb_req_t                        head,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; stale slots are masked by the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off          = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, off} < count);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file write port.
// Merges single-cycle ALU results (A) with buffered long-latency results (B),
// with a starvation counter that forces B after STARVE_MAX consecutive A wins.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data  ALU result handshake
//   b_valid/b_ready/b_addr/b_data  long-latency result handshake into the FIFO
//   wr_en/wr_addr/wr_data          registered register-file write port
//   pend_mask                      registers with a write still in flight
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] pend_mask
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                             full;
  logic                             empty;
  wb_req_t                          head;
  logic [FIFO_DEPTH-1:0]            ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [SW-1:0]                    starve;
  logic                             force_b;
  logic                             grant_a;
  logic                             grant_b;
  logic                             push;

  assign force_b = !empty && (starve == SW'(STARVE_MAX));
  assign grant_b = !rst && !empty && (force_b || !a_valid);
  assign grant_a = !rst && a_valid && !force_b;
  assign a_ready = !rst && !force_b;
  assign b_ready = !rst && !full;
  assign push    = b_valid && b_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (grant_b),
    .din       ('{addr: b_addr, data: b_data}),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Consecutive A wins while B waits; any pop or an empty FIFO clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (grant_b || empty) begin
      starve <= '0;
    end else if (grant_a && starve != SW'(STARVE_MAX)) begin
      starve <= starve + 1'b1;
    end
  end

  // ---- stage boundary: grant -> registered write port ----
  // Writes to r0 complete their handshake but never raise wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grant_a) begin
      wr_en   <= (a_addr != ADDR_W'(REG_ZERO));
      wr_addr <= a_addr;
      wr_data <= a_data;
    end else if (grant_b) begin
      wr_en   <= (head.addr != ADDR_W'(REG_ZERO));
      wr_addr <= head.addr;
      wr_data <= head.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pend_mask = pend_mask | reg_onehot(ent_addr[i]);
    end
    if (wr_en) pend_mask = pend_mask | reg_onehot(wr_addr);
    pend_mask[REG_ZERO] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready, wr_en;
  logic [4:0]  a_addr, b_addr, wr_addr;
  logic [31:0] a_data, b_data, wr_data, pend_mask;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_mask(pend_mask)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        zchk;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  exp_t        exq[$];
  ent_t        mq[$];
  int          starve = 0;
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model predicts the outcome and
  // queues what the write port must show after the coming edge.
  task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    int   cnt;
    bit   frc, ear, ebr, g, a_won, popped;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic [31:0] m;
    ent_t e;
    exp_t x;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    cnt = mq.size();
    frc = (cnt > 0) && (starve == SMAX);
    ear = !r && !frc;
    ebr = !r && (cnt < DEPTH);
    chk("a_ready", a_ready, ear);
    chk("b_ready", b_ready, ebr);
    x.zchk = 1'b0;
    if (r) begin
      mq.delete();
      starve = 0; m_en = 0; m_addr = '0; m_data = '0;
      x.zchk = 1'b1;
    end else begin
      g = 0; a_won = 0; popped = 0; ga = '0; gd = '0;
      if (cnt > 0 && (frc || !av)) begin
        e = mq.pop_front();
        g = 1; popped = 1; ga = e.a; gd = e.d;
      end else if (av) begin
        g = 1; a_won = 1; ga = aa; gd = ad;
      end
      if (bv && ebr) mq.push_back('{a: ba, d: bd});
      if (popped || cnt == 0) starve = 0;
      else if (a_won && starve < SMAX) starve++;
      if (g) begin
        m_en = (ga != 5'd0); m_addr = ga; m_data = gd;
      end else begin
        m_en = 0;
      end
    end
    m = '0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    if (m_en) m[m_addr] = 1'b1;
    m[0] = 1'b0;
    x.en = m_en; x.addr = m_addr; x.data = m_data; x.mask = m;
    exq.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Monitor: compares the write port against the queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("wr_en", wr_en, e.en);
        if (e.en || e.zchk) begin
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
        chk("pend_mask", pend_mask, e.mask);
      end
    end
  end

  initial begin
    rst = 1; a_valid = 0; b_valid = 0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // A stream on an empty FIFO
    step(0, 1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
    step(0, 1, 5'd2, 32'h22, 0, 5'd0, 32'd0);
    step(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
    idle(2);

    // Single B through an empty FIFO (two-cycle latency, no bypass)
    step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
    idle(4);

    // Starvation: A held valid, B fills the FIFO, AAAB pattern until drained
    for (int i = 0; i < 24; i++)
      step(0, 1, 5'(1 + (i % 15)), 32'hA000 + i, (i < 6), 5'(16 + i), 32'hB000 + i);
    idle(3);

    // r0 from both sources
    step(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h1234);
    idle(3);

    // Full FIFO: pop with b_valid high refuses the push, next cycle accepts
    for (int i = 0; i < 4; i++) step(0, 1, 5'(1 + i), 32'hC0 + i, 1, 5'(20 + i), 32'hD0 + i);
    step(0, 0, 5'd0, 32'd0, 1, 5'd24, 32'hD4);
    step(0, 1, 5'd6, 32'hC6, 1, 5'd24, 32'hD4);
    idle(10);

    // Reset with entries queued: they must never be written
    step(0, 1, 5'd7, 32'h70, 1, 5'd25, 32'h250);
    step(0, 1, 5'd8, 32'h80, 1, 5'd26, 32'h260);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(4);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
    idle(8);

    @(posedge clk);
    #2;
    chk("drain", exq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
